// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache-side line port (dfp_*) and the memory-side burst port (bmem_*).
// The adapter takes the slave view; the cache/memory environment takes the master view.
interface cacheline_adapter_if #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
);
   localparam int LINE_W = BEAT_W * BEATS;

   logic [31:0]       dfp_addr;
   logic              dfp_read;
   logic              dfp_write;
   logic [LINE_W-1:0] dfp_wdata;
   logic [LINE_W-1:0] dfp_rdata;
   logic              dfp_resp;

   logic [31:0]       bmem_addr;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic              bmem_ready;
   logic [BEAT_W-1:0] bmem_rdata;
   logic              bmem_rvalid;

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp,
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_rdata, bmem_rvalid
   );

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp,
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit cache line read/write into a 4-beat burst on the memory port,
// packing read beats into a line and splitting write lines into beats.
module cacheline_adapter #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic               clk,
   input  logic               rst,
   cacheline_adapter_if.slave bus
);
   localparam int                LINE_W     = BEAT_W * BEATS;
   localparam int                CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [31:0]       ALIGN_MASK = ~32'h1F;

   generate
      if (LINE_W != 256) begin : g_bad_geometry
         $error("cacheline_adapter: BEAT_W*BEATS must equal 256");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       addr_reg, addr_next;
   logic [LINE_W-1:0] line_reg, line_next;
   logic [LINE_W-1:0] rdata_reg, rdata_next;
   logic [BEAT_W-1:0] beat_w [BEATS];

   // Beat view of the line buffer; beat 0 is the least significant slice.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_w[gi] = line_reg[gi*BEAT_W +: BEAT_W];
   end

   assign bus.dfp_rdata = rdata_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         line_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         line_reg  <= line_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      addr_next       = addr_reg;
      line_next       = line_reg;
      rdata_next      = rdata_reg;
      bus.dfp_resp    = 1'b0;
      bus.bmem_addr   = '0;
      bus.bmem_read   = 1'b0;
      bus.bmem_write  = 1'b0;
      bus.bmem_wdata  = '0;

      case (state_reg)
         IDLE: begin
            // Write has priority when both requests are raised together.
            if (bus.dfp_write) begin
               addr_next  = bus.dfp_addr & ALIGN_MASK;
               line_next  = bus.dfp_wdata;
               cnt_next   = '0;
               state_next = WR_DATA;
            end else if (bus.dfp_read) begin
               addr_next  = bus.dfp_addr & ALIGN_MASK;
               cnt_next   = '0;
               state_next = RD_REQ;
            end
         end
         RD_REQ: begin
            bus.bmem_read = 1'b1;
            bus.bmem_addr = addr_reg;
            if (bus.bmem_ready) begin
               cnt_next   = '0;
               state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.bmem_rvalid) begin
               line_next[cnt_reg*BEAT_W +: BEAT_W] = bus.bmem_rdata;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_BEAT) begin
                  rdata_next = line_next;
                  state_next = DONE;
               end
            end
         end
         WR_DATA: begin
            bus.bmem_write = 1'b1;
            bus.bmem_addr  = addr_reg;
            bus.bmem_wdata = beat_w[cnt_reg];
            if (bus.bmem_ready) begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_BEAT) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // Always return through IDLE so a request held over DONE is not re-accepted.
            bus.dfp_resp = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder for the cache's 256-bit line interface (dfp_* signals), placed between the cache and main memory.
- Each line read or line write from the cache becomes one 4-beat, 64-bit burst transaction on the burst-memory (bmem_*) port.
- Packs returned read beats into a full line; splits write lines into beats.
- Exactly one line transaction is in flight at a time.

Parameters:
- BEAT_W, 64, burst beat width in bits.
- BEATS, 4, beats per line. BEAT_W*BEATS must equal 256; the design checks this at elaboration.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst  in  1  synchronous, active-low reset. rst==0 at a rising edge resets the block.
- dfp_addr  in  32  line request address from the cache.
- dfp_read  in  1  line read request; held until dfp_resp.
- dfp_write  in  1  line write request; held until dfp_resp.
- dfp_wdata  in  256  write line; held stable with dfp_write.
- dfp_rdata  out  256  assembled read line.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  line-aligned burst address.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  burst write beat valid.
- bmem_wdata  out  64  write beat data.
- bmem_ready  in  1  memory accepts the command or beat this cycle.
- bmem_rdata  in  64  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset values: every output 0, state IDLE, beat counter 0, line buffer 0.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE.
- IDLE:
  - On dfp_write: latch {dfp_addr[31:5],5'b0} and dfp_wdata, then go to WR_DATA.
  - Else on dfp_read: latch the aligned address, then go to RD_REQ.
  - If dfp_read and dfp_write are both 1, write wins.
  - The request is sampled only in IDLE.
- RD_REQ:
  - bmem_read=1 and bmem_addr=latched address.
  - When bmem_ready=1, go to RD_DATA with cnt=0. Otherwise hold.
- RD_DATA:
  - On each bmem_rvalid, write bmem_rdata into buffer[cnt*64 +: 64]. Beat 0 is line bits 63:0.
  - cnt increments, mod BEATS.
  - Gaps between beats are allowed and the block waits.
  - On the beat with cnt==BEATS-1, go to DONE.
- WR_DATA:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=buffer[cnt*64 +: 64].
  - A beat is consumed only when bmem_ready=1; otherwise hold the same beat and data.
  - When the last beat is accepted, go to DONE.
- DONE:
  - dfp_resp=1 for exactly one cycle, then go to IDLE.
  - For reads, dfp_rdata is valid in this cycle.
- dfp_rdata is a register. It is updated only by a read completion and holds until the next read completes; a write does not disturb it.
- bmem_read and bmem_write are never asserted together, and never outside RD_REQ or WR_DATA respectively.
- bmem_rvalid is ignored in every state except RD_DATA.
- Requester contract: the cache drops its request in the cycle after dfp_resp.
  - Because DONE always passes through IDLE before a request is sampled, a request still high during the DONE cycle is never double-accepted.
  - A request still high in the following IDLE cycle is treated as a new request.
- Minimum latency:
  - Read: 1 (IDLE) + 1 (RD_REQ, ready) + 4 beats + DONE = resp on cycle 6 after request assertion, counting the request cycle as 0.
  - Write: 1 + 4 + 1, resp on cycle 5.
- Reset mid-operation:
  - Aborts the transaction immediately, with outputs 0 in the next cycle.
  - The partial line is discarded and the counter is cleared.
  - Late rvalid beats arriving after reset are ignored in IDLE.
- The low 5 address bits are always forced to 0 on bmem_addr.

Test Plan:
1. Read to 0x0000_1234, bmem_ready=1, rvalid on 4 consecutive cycles with beats 0x0..00,0x..11,0x..22,0x..33 → bmem_addr=0x0000_1220 and one bmem_read cycle; dfp_resp on cycle 6 with dfp_rdata={beat3,beat2,beat1,beat0}.
2. Read with bmem_ready low for 3 cycles and 2-cycle gaps between rvalid beats → bmem_read held for 4 cycles; correct line assembled; single dfp_resp pulse.
3. Write of line 0xFFEE..00 to 0x8000_0040 with bmem_ready toggling 1,0,1,0,1,1 → beats issued in order [63:0]..[255:192], each beat held while ready=0; dfp_resp one cycle after the 4th accepted beat; prior dfp_rdata unchanged.
4. dfp_read and dfp_write both high → write burst only; bmem_read never asserted.
5. Back-to-back: write then read, with the request held through the DONE cycle → exactly one dfp_resp per transaction; no duplicate burst.
6. rst=0 after 2 read beats, then 2 stray rvalid pulses, then a new read → stray beats ignored; the new read returns only its own 4 beats.
